// File: rtl/uart_axi_buffer.sv
// ---------------------------------------------------------------------------
// uart_axi_buffer
//   AXI4-Lite responder sitting between the core's uart_axi_* master port and
//   the UART PHY. Holds a TX byte FIFO (drained by the serializer) and an RX
//   byte FIFO (filled by the deserializer), and exposes four registers selected
//   by addr[3:2]:
//     0 RX   : read pops the RX head byte (0 when empty)
//     1 TX   : write with wstrb[0] pushes wdata[7:0]
//     2 STAT : {overrun, irq_en, tx_full, tx_empty, rx_full, rx_nonempty}
//              read clears overrun
//     3 CTRL : write with wstrb[0]: bit0 flush TX, bit1 flush RX, bit4 irq_en
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   uart_axi_aw*/w*/b*              AXI4-Lite write address/data/response
//   uart_axi_ar*/r*                 AXI4-Lite read address/data
//   tx_data, tx_valid, tx_ready     TX FIFO head to serializer (pop on hs)
//   rx_data, rx_valid               RX byte strobe from deserializer
//   irq                             registered level interrupt
// ---------------------------------------------------------------------------
module uart_axi_buffer #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] uart_axi_awaddr,
    input  logic                  uart_axi_awvalid,
    output logic                  uart_axi_awready,
    input  logic [31:0]           uart_axi_wdata,
    input  logic [3:0]            uart_axi_wstrb,
    input  logic                  uart_axi_wvalid,
    output logic                  uart_axi_wready,
    output logic [1:0]            uart_axi_bresp,
    output logic                  uart_axi_bvalid,
    input  logic                  uart_axi_bready,

    input  logic [ADDR_WIDTH-1:0] uart_axi_araddr,
    input  logic                  uart_axi_arvalid,
    output logic                  uart_axi_arready,
    output logic [31:0]           uart_axi_rdata,
    output logic [1:0]            uart_axi_rresp,
    output logic                  uart_axi_rvalid,
    input  logic                  uart_axi_rready,

    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,

    output logic                  irq
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] SEL_RX   = 2'd0;
    localparam logic [1:0] SEL_TX   = 2'd1;
    localparam logic [1:0] SEL_STAT = 2'd2;
    localparam logic [1:0] SEL_CTRL = 2'd3;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // r_active keeps every ready low while rst is held and for the reset
    // cycle itself, so readies rise only the cycle after rst falls.
    logic            r_active;

    logic [0:0]      r_wstate;
    logic            r_aw_got;
    logic            r_w_got;
    logic [1:0]      r_aw_sel;
    logic [7:0]      r_wdata;
    logic            r_wstrb0;

    logic [0:0]      r_rstate;
    logic [31:0]     r_rdata;

    logic [7:0]      r_tx_mem [DEPTH];
    logic [PW-1:0]   r_tx_wptr;
    logic [PW-1:0]   r_tx_rptr;
    logic [CW-1:0]   r_tx_count;

    logic [7:0]      r_rx_mem [DEPTH];
    logic [PW-1:0]   r_rx_wptr;
    logic [PW-1:0]   r_rx_rptr;
    logic [CW-1:0]   r_rx_count;

    logic            r_overrun;
    logic            r_irq_en;
    logic            r_irq;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_wr_fire;
    logic [1:0]      w_wr_sel;
    logic [7:0]      w_wr_data;
    logic            w_wr_strb0;

    logic            w_ar_hs;
    logic [1:0]      w_rd_sel;
    logic [31:0]     w_rdata_d;

    logic            w_tx_empty;
    logic            w_tx_full;
    logic            w_rx_empty;
    logic            w_rx_full;

    logic            w_tx_push;
    logic            w_tx_push_ok;
    logic            w_tx_pop;
    logic            w_tx_flush;
    logic            w_rx_push_ok;
    logic            w_rx_pop;
    logic            w_rx_flush;
    logic            w_ctrl_wr;
    logic            w_stat_rd;

    logic [CW-1:0]   w_tx_count_d;
    logic [CW-1:0]   w_rx_count_d;
    logic            w_overrun_d;
    logic            w_irq_en_d;
    logic            w_irq_d;

    logic            w_unused;

    assign w_tx_empty = (r_tx_count == '0);
    assign w_tx_full  = (r_tx_count == FULL_COUNT);
    assign w_rx_empty = (r_rx_count == '0);
    assign w_rx_full  = (r_rx_count == FULL_COUNT);

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    assign uart_axi_awready = r_active && (r_wstate == W_IDLE) && !r_aw_got;
    assign uart_axi_wready  = r_active && (r_wstate == W_IDLE) && !r_w_got;
    assign uart_axi_bvalid  = (r_wstate == W_RESP);
    assign uart_axi_bresp   = 2'b00;

    assign w_aw_hs = uart_axi_awvalid && uart_axi_awready;
    assign w_w_hs  = uart_axi_wvalid && uart_axi_wready;

    // Ready is low once a beat is latched, so a latched value and a live
    // handshake never coexist; pick whichever one exists.
    assign w_wr_sel   = r_aw_got ? r_aw_sel : uart_axi_awaddr[3:2];
    assign w_wr_data  = r_w_got ? r_wdata : uart_axi_wdata[7:0];
    assign w_wr_strb0 = r_w_got ? r_wstrb0 : uart_axi_wstrb[0];

    assign w_wr_fire = (r_wstate == W_IDLE) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_wstate <= W_IDLE;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_aw_sel <= 2'b00;
            r_wdata  <= 8'h00;
            r_wstrb0 <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (r_wstate == W_IDLE) begin
                if (w_wr_fire) begin
                    r_wstate <= W_RESP;
                    r_aw_got <= 1'b0;
                    r_w_got  <= 1'b0;
                end else begin
                    if (w_aw_hs) begin
                        r_aw_got <= 1'b1;
                        r_aw_sel <= uart_axi_awaddr[3:2];
                    end
                    if (w_w_hs) begin
                        r_w_got  <= 1'b1;
                        r_wdata  <= uart_axi_wdata[7:0];
                        r_wstrb0 <= uart_axi_wstrb[0];
                    end
                end
            end else if (uart_axi_bready) begin
                r_wstate <= W_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    assign uart_axi_arready = r_active && (r_rstate == R_IDLE);
    assign uart_axi_rvalid  = (r_rstate == R_DATA);
    assign uart_axi_rdata   = r_rdata;
    assign uart_axi_rresp   = 2'b00;

    assign w_ar_hs  = uart_axi_arvalid && uart_axi_arready;
    assign w_rd_sel = uart_axi_araddr[3:2];

    always_comb begin
        w_rdata_d = 32'h0;
        unique case (w_rd_sel)
            SEL_RX:   w_rdata_d = w_rx_empty ? 32'h0 : {24'h0, r_rx_mem[r_rx_rptr]};
            SEL_STAT: w_rdata_d = {26'h0, r_overrun, r_irq_en, w_tx_full, w_tx_empty,
                                   w_rx_full, !w_rx_empty};
            default:  w_rdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rdata  <= 32'h0;
        end else if (r_rstate == R_IDLE) begin
            if (w_ar_hs) begin
                r_rstate <= R_DATA;
                r_rdata  <= w_rdata_d;
            end
        end else if (uart_axi_rready) begin
            r_rstate <= R_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Register side effects
    // ------------------------------------------------------------------
    assign w_tx_push    = w_wr_fire && (w_wr_sel == SEL_TX) && w_wr_strb0;
    assign w_tx_push_ok = w_tx_push && !w_tx_full;
    assign w_tx_pop     = !w_tx_empty && tx_ready;

    assign w_ctrl_wr  = w_wr_fire && (w_wr_sel == SEL_CTRL) && w_wr_strb0;
    assign w_tx_flush = w_ctrl_wr && w_wr_data[0];
    assign w_rx_flush = w_ctrl_wr && w_wr_data[1];

    // A full RX FIFO drops the byte even when a read pops it the same cycle.
    assign w_rx_push_ok = rx_valid && !w_rx_full;
    assign w_rx_pop     = w_ar_hs && (w_rd_sel == SEL_RX) && !w_rx_empty;
    assign w_stat_rd    = w_ar_hs && (w_rd_sel == SEL_STAT);

    // Setting overrun wins over a same-cycle STAT read clear.
    assign w_overrun_d = (r_overrun && !w_stat_rd) || (w_tx_push && w_tx_full) ||
                         (rx_valid && w_rx_full);
    assign w_irq_en_d  = w_ctrl_wr ? w_wr_data[4] : r_irq_en;

    always_comb begin
        w_tx_count_d = r_tx_count;
        if (w_tx_flush) begin
            w_tx_count_d = '0;
        end else if (w_tx_push_ok && !w_tx_pop) begin
            w_tx_count_d = r_tx_count + CW'(1);
        end else if (!w_tx_push_ok && w_tx_pop) begin
            w_tx_count_d = r_tx_count - CW'(1);
        end
    end

    always_comb begin
        w_rx_count_d = r_rx_count;
        if (w_rx_flush) begin
            w_rx_count_d = '0;
        end else if (w_rx_push_ok && !w_rx_pop) begin
            w_rx_count_d = r_rx_count + CW'(1);
        end else if (!w_rx_push_ok && w_rx_pop) begin
            w_rx_count_d = r_rx_count - CW'(1);
        end
    end

    // irq is registered from next-state values so it tracks the FIFOs
    // without an extra cycle of lag.
    assign w_irq_d = w_irq_en_d && ((w_rx_count_d != '0) || (w_tx_count_d == '0));

    // ------------------------------------------------------------------
    // FIFO storage (no reset; validity is tracked by the counters)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_tx_push_ok) begin
            r_tx_mem[r_tx_wptr] <= w_wr_data;
        end
        if (w_rx_push_ok) begin
            r_rx_mem[r_rx_wptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
            r_overrun  <= 1'b0;
            r_irq_en   <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_tx_count <= w_tx_count_d;
            r_rx_count <= w_rx_count_d;
            r_overrun  <= w_overrun_d;
            r_irq_en   <= w_irq_en_d;
            r_irq      <= w_irq_d;

            if (w_tx_flush) begin
                r_tx_wptr <= '0;
                r_tx_rptr <= '0;
            end else begin
                if (w_tx_push_ok) r_tx_wptr <= r_tx_wptr + PW'(1);
                if (w_tx_pop)     r_tx_rptr <= r_tx_rptr + PW'(1);
            end

            if (w_rx_flush) begin
                r_rx_wptr <= '0;
                r_rx_rptr <= '0;
            end else begin
                if (w_rx_push_ok) r_rx_wptr <= r_rx_wptr + PW'(1);
                if (w_rx_pop)     r_rx_rptr <= r_rx_rptr + PW'(1);
            end
        end
    end

    assign tx_data  = r_tx_mem[r_tx_rptr];
    assign tx_valid = !w_tx_empty;
    assign irq      = r_irq;

    // Address and data bits outside the decoded fields are intentionally ignored.
    assign w_unused = ^{uart_axi_awaddr[ADDR_WIDTH-1:4], uart_axi_awaddr[1:0],
                        uart_axi_araddr[ADDR_WIDTH-1:4], uart_axi_araddr[1:0],
                        uart_axi_wdata[31:8], uart_axi_wstrb[3:1]};

endmodule

// File: tb/tb_uart_axi_buffer.sv
module tb_uart_axi_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        irq;

    uart_axi_buffer #(
        .DEPTH_LOG2 (4),
        .ADDR_WIDTH (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .uart_axi_awaddr  (awaddr),
        .uart_axi_awvalid (awvalid),
        .uart_axi_awready (awready),
        .uart_axi_wdata   (wdata),
        .uart_axi_wstrb   (wstrb),
        .uart_axi_wvalid  (wvalid),
        .uart_axi_wready  (wready),
        .uart_axi_bresp   (bresp),
        .uart_axi_bvalid  (bvalid),
        .uart_axi_bready  (bready),
        .uart_axi_araddr  (araddr),
        .uart_axi_arvalid (arvalid),
        .uart_axi_arready (arready),
        .uart_axi_rdata   (rdata),
        .uart_axi_rresp   (rresp),
        .uart_axi_rvalid  (rvalid),
        .uart_axi_rready  (rready),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: byte queues plus the two control bits.
    logic [7:0] q_tx[$];
    logic [7:0] q_rx[$];
    logic       m_overrun;
    logic       m_irq_en;

    function automatic logic [31:0] model_stat();
        logic [31:0] s;
        s    = 32'h0;
        s[0] = (q_rx.size() != 0);
        s[1] = (q_rx.size() == DEPTH);
        s[2] = (q_tx.size() == 0);
        s[3] = (q_tx.size() == DEPTH);
        s[4] = m_irq_en;
        s[5] = m_overrun;
        return s;
    endfunction

    function automatic logic model_irq();
        return m_irq_en && ((q_rx.size() != 0) || (q_tx.size() == 0));
    endfunction

    function automatic logic [31:0] rand_addr(input logic [1:0] sel);
        logic [31:0] a;
        a      = $urandom;
        a[3:2] = sel;
        return a;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb);
        if (strb[0]) begin
            if (addr[3:2] == 2'd1) begin
                if (q_tx.size() < DEPTH) q_tx.push_back(data[7:0]);
                else m_overrun = 1'b1;
            end else if (addr[3:2] == 2'd3) begin
                if (data[0]) q_tx.delete();
                if (data[1]) q_rx.delete();
                m_irq_en = data[4];
            end
        end
    endtask

    // AW and W presented together; response expected the cycle after.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        #1;
        checks++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            failures++;
            $display("FAIL wr_ready got aw=%b w=%b exp 1/1", awready, wready);
        end
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        model_write(addr, data, strb);
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            failures++;
            $display("FAIL wr_bvalid_latency got bvalid=%b bresp=%b exp 1/00", bvalid, bresp);
        end
        checks++;
        if (irq !== model_irq()) begin
            failures++;
            $display("FAIL wr_irq got=%b exp=%b", irq, model_irq());
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            failures++;
            $display("FAIL wr_bvalid_drop got=%b exp=0", bvalid);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        araddr  = addr;
        arvalid = 1'b1;
        #1;
        checks++;
        if (arready !== 1'b1) begin
            failures++;
            $display("FAIL rd_arready got=%b exp=1", arready);
        end
        @(negedge clk);
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rresp !== 2'b00) begin
            failures++;
            $display("FAIL rd_rvalid_latency got rvalid=%b rresp=%b exp 1/00", rvalid, rresp);
        end
        data   = rdata;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rd_rvalid_drop got=%b exp=0", rvalid);
        end
    endtask

    task automatic read_check(input logic [31:0] addr, input string name);
        logic [31:0] exp;
        logic [31:0] got;
        exp = 32'h0;
        if (addr[3:2] == 2'd0) begin
            if (q_rx.size() != 0) exp = {24'h0, q_rx.pop_front()};
        end else if (addr[3:2] == 2'd2) begin
            exp       = model_stat();
            m_overrun = 1'b0;
        end
        axi_read(addr, got);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic rx_push(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        if (q_rx.size() < DEPTH) q_rx.push_back(d);
        else m_overrun = 1'b1;
    endtask

    task automatic drain_all();
        tx_ready = 1'b1;
        while (q_tx.size() != 0) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== q_tx[0]) begin
                failures++;
                $display("FAIL tx_drain got valid=%b data=%h exp 1/%h", tx_valid, tx_data, q_tx[0]);
            end
            @(negedge clk);
            void'(q_tx.pop_front());
        end
        tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL tx_empty_after_drain got=%b exp=0", tx_valid);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, tx_valid, irq} !== 7'b0 ||
            rdata !== 32'h0) begin
            failures++;
            $display("FAIL %s got aw=%b w=%b ar=%b b=%b r=%b txv=%b irq=%b rdata=%h exp all 0",
                     name, awready, wready, arready, bvalid, rvalid, tx_valid, irq, rdata);
        end
    endtask

    task automatic release_reset();
        rst = 1'b0;
        q_tx.delete();
        q_rx.delete();
        m_overrun = 1'b0;
        m_irq_en  = 1'b0;
        #1;
        check_reset_outputs("ready_low_at_release");
        @(negedge clk);
        checks++;
        if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
            failures++;
            $display("FAIL ready_rise got aw=%b w=%b ar=%b exp 1/1/1", awready, wready, arready);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        awaddr   = 32'h0;
        awvalid  = 1'b0;
        wdata    = 32'h0;
        wstrb    = 4'h0;
        wvalid   = 1'b0;
        bready   = 1'b0;
        araddr   = 32'h0;
        arvalid  = 1'b0;
        rready   = 1'b0;
        tx_ready = 1'b0;
        rx_data  = 8'h0;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_outputs");
        release_reset();
        read_check(rand_addr(2'd2), "reset_stat");
    endtask

    task automatic test_tx_order();
        axi_write(rand_addr(2'd1), 32'h41, 4'h1);
        axi_write(rand_addr(2'd1), 32'h42, 4'h1);
        repeat (3) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
                failures++;
                $display("FAIL tx_hold got valid=%b data=%h exp 1/41", tx_valid, tx_data);
            end
            @(negedge clk);
        end
        drain_all();
    endtask

    task automatic test_rx_basic();
        rx_push(8'h5A);
        read_check(rand_addr(2'd2), "rx_stat_nonempty");
        read_check(rand_addr(2'd0), "rx_read_5a");
        read_check(rand_addr(2'd0), "rx_read_empty");
        read_check(rand_addr(2'd2), "rx_stat_empty");
    endtask

    task automatic test_rx_overrun();
        logic [31:0] got;
        for (int i = 0; i < DEPTH + 1; i++) rx_push(8'(8'h10 + i));
        axi_read(rand_addr(2'd2), got);
        checks++;
        if (got !== 32'h27) begin
            failures++;
            $display("FAIL overrun_stat got=%h exp=%h", got, 32'h27);
        end
        m_overrun = 1'b0;
        read_check(rand_addr(2'd2), "overrun_cleared");
        for (int i = 0; i < DEPTH; i++) read_check(rand_addr(2'd0), "overrun_rx_data");
        read_check(rand_addr(2'd0), "overrun_17th_lost");
    endtask

    task automatic hold_response(input string name);
        checks++;
        if (bvalid !== 1'b1) begin
            failures++;
            $display("FAIL %s_bvalid got=%b exp=1", name, bvalid);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
                failures++;
                $display("FAIL %s_hold got b=%b aw=%b w=%b exp 1/0/0", name, bvalid, awready,
                         wready);
            end
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            failures++;
            $display("FAIL %s_release got=%b exp=0", name, bvalid);
        end
    endtask

    task automatic test_split_write();
        // AW three cycles ahead of W.
        awaddr  = rand_addr(2'd1);
        awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        repeat (2) begin
            checks++;
            if (awready !== 1'b0 || wready !== 1'b1 || bvalid !== 1'b0) begin
                failures++;
                $display("FAIL aw_first_wait got aw=%b w=%b b=%b exp 0/1/0", awready, wready,
                         bvalid);
            end
            @(negedge clk);
        end
        wdata  = 32'hFFFF_FF77;
        wstrb  = 4'h1;
        wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        q_tx.push_back(8'h77);
        hold_response("aw_first");

        // W ahead of AW.
        wdata  = 32'h88;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        checks++;
        if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
            failures++;
            $display("FAIL w_first_wait got w=%b aw=%b b=%b exp 0/1/0", wready, awready, bvalid);
        end
        @(negedge clk);
        awaddr  = rand_addr(2'd1);
        awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        q_tx.push_back(8'h88);
        hold_response("w_first");
        drain_all();
    endtask

    task automatic test_ctrl_flush_and_reset();
        logic [31:0] got;
        axi_write(rand_addr(2'd1), 32'hA1, 4'h1);
        axi_write(rand_addr(2'd1), 32'hA2, 4'h1);
        rx_push(8'h33);
        axi_write(rand_addr(2'd3), 32'h13, 4'h1);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL flush_irq got=%b exp=1", irq);
        end
        read_check(rand_addr(2'd2), "flush_stat");
        // Reset while the read response is pending.
        araddr  = rand_addr(2'd2);
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_rvalid got=%b exp=1", rvalid);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_read_reset");
        release_reset();
        axi_read(rand_addr(2'd2), got);
        checks++;
        if (got !== 32'h04) begin
            failures++;
            $display("FAIL post_reset_stat got=%h exp=%h", got, 32'h04);
        end
    endtask

    task automatic test_random();
        int          op;
        logic [31:0] d;
        logic [1:0]  sel;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: rx_push(8'($urandom));
                1: axi_write(rand_addr(2'd1), $urandom, 4'($urandom_range(0, 15) | 1));
                2: read_check(rand_addr(2'd0), "rnd_rx_read");
                3: read_check(rand_addr(2'd2), "rnd_stat");
                4: begin
                    sel = 2'($urandom_range(0, 3));
                    read_check(rand_addr(sel), "rnd_any_read");
                end
                5: begin
                    tx_ready = 1'b1;
                    checks++;
                    if (tx_valid !== (q_tx.size() != 0) ||
                        (q_tx.size() != 0 && tx_data !== q_tx[0])) begin
                        failures++;
                        $display("FAIL rnd_tx_pop got valid=%b data=%h exp_size=%0d",
                                 tx_valid, tx_data, q_tx.size());
                    end
                    @(negedge clk);
                    tx_ready = 1'b0;
                    if (q_tx.size() != 0) void'(q_tx.pop_front());
                end
                6: begin
                    // Writes that must be ignored: RX/STAT, or strobe bit 0 clear.
                    sel = ($urandom_range(0, 1) != 0) ? 2'd0 : 2'd2;
                    if ($urandom_range(0, 1) != 0)
                        axi_write(rand_addr(sel), $urandom, 4'hF);
                    else
                        axi_write(rand_addr(2'($urandom_range(0, 3))), $urandom, 4'hE);
                end
                default: begin
                    d = 32'h0;
                    d[4] = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) d[0] = 1'b1;
                    if ($urandom_range(0, 3) == 0) d[1] = 1'b1;
                    axi_write(rand_addr(2'd3), d, 4'h1);
                end
            endcase
            checks++;
            if (irq !== model_irq() || tx_valid !== (q_tx.size() != 0)) begin
                failures++;
                $display("FAIL rnd_status got irq=%b txv=%b exp irq=%b txv=%b", irq, tx_valid,
                         model_irq(), (q_tx.size() != 0));
            end
        end
        read_check(rand_addr(2'd2), "rnd_final_stat");
        drain_all();
    endtask

    initial begin
        test_reset();
        test_tx_order();
        test_rx_basic();
        test_rx_overrun();
        test_split_write();
        test_ctrl_flush_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
